// File: rtl/pwm_gen.sv
// PWM generator fed by the APB register block (MEM0 = period, MEM1 = duty), pclk domain.
// Optional dead-time complementary output when PWM_DEADTIME_EN is defined.
module pwm_gen #(
  parameter int W        = 16,
  parameter int DEAD_CYC = 2
) (
  input  logic         pclk,
  input  logic         rsn,
  input  logic [W-1:0] MEM0,
  input  logic [W-1:0] MEM1,
  input  logic         pwm_en,
  output logic         pwm_out,
`ifdef PWM_DEADTIME_EN
  output logic         pwm_out_n,
`endif
  output logic         period_end
);

  logic [W-1:0] cnt;
  logic [W-1:0] per_sh;
  logic [W-1:0] duty_sh;
  logic         raw;
  logic         wrap;

  always_comb begin
    raw  = (cnt < duty_sh);
    wrap = (cnt == per_sh);
  end

  // Shadows follow MEM0/MEM1 while idle and reload only at wrap while running.
  always_ff @(posedge pclk) begin
    if (!rsn) begin
      cnt        <= '0;
      per_sh     <= '0;
      duty_sh    <= '0;
      period_end <= 1'b0;
    end else if (!pwm_en) begin
      cnt        <= '0;
      per_sh     <= MEM0;
      duty_sh    <= MEM1;
      period_end <= 1'b0;
    end else if (wrap) begin
      cnt        <= '0;
      per_sh     <= MEM0;
      duty_sh    <= MEM1;
      period_end <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      period_end <= 1'b0;
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [7:0] DC = 8'(DEAD_CYC);

  logic       raw_q;
  logic       run;
  logic [7:0] dcnt;
  logic [7:0] dcnt_nxt;

  // dcnt is the saturating age of the current raw phase; a phase starts at
  // every raw edge and also on the first enabled cycle.
  always_comb begin
    dcnt_nxt = '0;
    if (run && (raw == raw_q)) begin
      dcnt_nxt = (dcnt == DC) ? DC : dcnt + 8'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rsn || !pwm_en) begin
      raw_q     <= 1'b0;
      run       <= 1'b0;
      dcnt      <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      raw_q     <= raw;
      run       <= 1'b1;
      dcnt      <= dcnt_nxt;
      pwm_out   <= raw & (dcnt_nxt == DC);
      pwm_out_n <= ~raw & (dcnt_nxt == DC);
    end
  end
`else
  always_ff @(posedge pclk) begin
    if (!rsn || !pwm_en) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= raw;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Randomized and directed self-checking bench for pwm_gen against a per-cycle reference model.
// Builds with or without PWM_DEADTIME_EN.
module tb_pwm_gen;
  localparam int W        = 8;
  localparam int DEAD_CYC = 2;

  logic         pclk = 1'b0;
  logic         rsn;
  logic         pwm_en;
  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         pwm_out;
  logic         period_end;
`ifdef PWM_DEADTIME_EN
  logic         pwm_out_n;
`endif

  pwm_gen #(.W(W), .DEAD_CYC(DEAD_CYC)) dut (
    .pclk       (pclk),
    .rsn        (rsn),
    .MEM0       (mem0),
    .MEM1       (mem1),
    .pwm_en     (pwm_en),
    .pwm_out    (pwm_out),
`ifdef PWM_DEADTIME_EN
    .pwm_out_n  (pwm_out_n),
`endif
    .period_end (period_end)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: position in period, latched period/duty, phase age.
  int m_pos = 0, m_per = 0, m_duty = 0, m_run = 0;
  bit m_prev = 0;
  bit e_out = 0, e_outn = 0, e_pe = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input string tag);
    bit r;
    @(posedge pclk);
    if (!rsn || !pwm_en) begin
      m_pos  = 0;
      m_per  = rsn ? int'(mem0) : 0;
      m_duty = rsn ? int'(mem1) : 0;
      m_run  = 0;
      e_out  = 0;
      e_outn = 0;
      e_pe   = 0;
    end else begin
      r      = (m_pos < m_duty);
      m_run  = (m_run > 0 && r == m_prev) ? m_run + 1 : 1;
      m_prev = r;
`ifdef PWM_DEADTIME_EN
      e_out  = r && (m_run > DEAD_CYC);
      e_outn = !r && (m_run > DEAD_CYC);
`else
      e_out  = r;
`endif
      e_pe = (m_pos == m_per);
      if (e_pe) begin
        m_pos  = 0;
        m_per  = int'(mem0);
        m_duty = int'(mem1);
      end else begin
        m_pos++;
      end
    end
    #1;
    check({tag, "_pwm"}, pwm_out, e_out);
    check({tag, "_pe"}, period_end, e_pe);
`ifdef PWM_DEADTIME_EN
    check({tag, "_pwmn"}, pwm_out_n, e_outn);
`endif
  endtask

  task automatic reload(input int p, input int d);
    pwm_en = 1'b0;
    mem0   = W'(p);
    mem1   = W'(d);
    step("idle");
    pwm_en = 1'b1;
  endtask

  initial begin
    int hi0, hi1, cnt_hi, cnt_lo, cnt_gap;
    bit pat [5];
    pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 0;
    rsn = 1'b0; pwm_en = 1'b0; mem0 = '0; mem1 = '0;
    #1;
    step("rst");
    step("rst");
    check("rst_pwm_const", pwm_out, 0);
    check("rst_pe_const", period_end, 0);

    // Basic 5-cycle period, 2 high
    rsn = 1'b1;
    reload(4, 2);
    for (int i = 0; i < 15; i++) begin
      step("t1");
`ifndef PWM_DEADTIME_EN
      check("t1_pattern", pwm_out, pat[i % 5]);
`endif
      check("t1_pe_every5", period_end, (i % 5) == 4);
    end

    // Duty extremes
    reload(4, 0);
    for (int i = 0; i < 10; i++) begin
      step("t2a");
      check("t2a_low", pwm_out, 0);
      check("t2a_pe", period_end, (i % 5) == 4);
    end
    reload(4, 7);
    for (int i = 0; i < 10; i++) begin
      step("t2b");
`ifndef PWM_DEADTIME_EN
      check("t2b_high", pwm_out, 1);
`endif
      check("t2b_pe", period_end, (i % 5) == 4);
    end

    // Mid-period duty write only applies from next wrap
    reload(9, 3);
    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 20; i++) begin
      step("t3");
      if (i == 1) mem1 = W'(6);
      if (i < 10) hi0 += int'(pwm_out); else hi1 += int'(pwm_out);
    end
`ifndef PWM_DEADTIME_EN
    check("t3_hi_first", hi0, 3);
    check("t3_hi_second", hi1, 6);
`endif

    // Single-cycle period, then disable
    reload(0, 1);
    for (int i = 0; i < 6; i++) begin
      step("t4");
`ifndef PWM_DEADTIME_EN
      check("t4_high", pwm_out, 1);
`endif
      check("t4_pe", period_end, 1);
    end
    pwm_en = 1'b0;
    step("t4off");
    check("t4off_pwm", pwm_out, 0);
    check("t4off_pe", period_end, 0);

    // Reset mid-period overrides enable
    reload(9, 3);
    for (int i = 0; i < 5; i++) step("t5");
    rsn = 1'b0;
    step("t5rst");
    check("t5rst_pwm", pwm_out, 0);
    check("t5rst_pe", period_end, 0);
    rsn = 1'b1;
    for (int i = 0; i < 25; i++) step("t5re");

    // All-ones period wraps cleanly
    reload((1 << W) - 1, 128);
    for (int i = 0; i < 260; i++) begin
      step("tmax");
      check("tmax_pe", period_end, i == 255);
    end

`ifdef PWM_DEADTIME_EN
    reload(9, 5);
    cnt_hi = 0; cnt_lo = 0; cnt_gap = 0;
    for (int i = 0; i < 20; i++) begin
      step("t6");
      if (i >= 10) begin
        cnt_hi  += int'(pwm_out);
        cnt_lo  += int'(pwm_out_n);
        cnt_gap += int'(!pwm_out && !pwm_out_n);
      end
    end
    check("t6_hi", cnt_hi, 3);
    check("t6_lo", cnt_lo, 3);
    check("t6_gap", cnt_gap, 4);
    reload(9, 2);
    cnt_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step("t6b");
      cnt_hi += int'(pwm_out);
    end
    check("t6b_nohi", cnt_hi, 0);
`else
    cnt_hi = 0; cnt_lo = 0; cnt_gap = 0;
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mem0 = W'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) mem1 = W'($urandom_range(0, 14));
      if ($urandom_range(0, 19) == 0) pwm_en = ~pwm_en;
      rsn = ($urandom_range(0, 59) != 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
